im_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Stores the words in a 128-entry instruction store and exposes the same word-aligned combinational fetch port the core already uses.
- Signals busy while loading, so the fetch stage sees NOPs until the program is fully in place.

---
 rtl/im_loader.sv | 98 +++++++++
 tb/tb_im_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Instruction-store loader: assembles little-endian words from a byte stream
// into a 128-entry memory and serves combinational word fetches (NOP while busy).
module im_loader #(
    parameter int          NMEM     = 128,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  nwords,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] addr,
    output logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);
    localparam int         AW   = $clog2(NMEM);
    localparam logic [7:0] NMAX = 8'(NMEM);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state;
    logic [7:0]      count;
    logic [AW-1:0]   waddr;
    logic [1:0]      cnt;
    logic [23:0]     shift;
    logic [31:0]     mem [NMEM];
    logic            accept;
    logic [31:0]     word;
    logic            unused_addr;

    assign busy       = (state == LOAD);
    assign byte_ready = (state == LOAD);
    assign done       = (state == DONE);
    assign accept     = byte_ready && byte_valid;
    assign word       = {byte_data, shift};

    // Fetch masks the store with NOPs until the whole program is in place.
    assign data        = busy ? NOP_WORD : mem[addr[AW+1:2]];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            waddr    <= '0;
            cnt      <= '0;
            shift    <= '0;
            err      <= 1'b0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (nwords == 8'd0 || nwords > NMAX) begin
                            err      <= 1'b1;
                            checksum <= '0;
                        end else begin
                            count    <= nwords;
                            waddr    <= '0;
                            cnt      <= '0;
                            checksum <= '0;
                            err      <= 1'b0;
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt == 2'd3) begin
                            checksum <= checksum ^ word;
                            cnt      <= '0;
                            waddr    <= waddr + 1'b1;
                            if (8'(waddr) == count - 8'd1)
                                state <= DONE;
                        end else begin
                            shift[8*cnt +: 8] <= byte_data;
                            cnt               <= cnt + 2'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The store itself is never reset; a reset edge must not commit a word.
    always_ff @(posedge clk) begin
        if (!rst && accept && cnt == 2'd3)
            mem[waddr] <= word;
    end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: stimulus queues expected probe and done
// results; a negedge monitor pops and compares them as the DUT presents them.
module tb_im_loader;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          K_DATA = 0;
    localparam int          K_BUSY = 1;
    localparam int          K_ERR  = 2;
    localparam int          K_SUM  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  nwords;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } probe_t;

    typedef struct {
        logic [31:0] sum;
        int          busy_cycles;
    } done_t;

    probe_t      exp_probe[$];
    string       probe_name[$];
    done_t       exp_done[$];
    logic        probe = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] words [128];

    always #5 clk = ~clk;

    im_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nwords     (nwords),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .addr       (addr),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum)
    );

    // Monitor: busy masking, done pulses and requested probes.
    always @(negedge clk) begin
        probe_t      p;
        done_t       d;
        string       nm;
        logic [31:0] act;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (addr == 32'd0) begin
                    checks++;
                    if (data !== NOP) begin
                        errors++;
                        $display("[TB] FAIL busy_mask: data=%h required %h", data, NOP);
                    end
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: done=1 required 0");
                end else begin
                    d = exp_done.pop_front();
                    checks += 2;
                    if (checksum !== d.sum) begin
                        errors++;
                        $display("[TB] FAIL done_checksum: checksum=%h required %h", checksum, d.sum);
                    end
                    if (busy_cnt != d.busy_cycles) begin
                        errors++;
                        $display("[TB] FAIL done_busy_cycles: busy for %0d cycles, required %0d",
                                 busy_cnt, d.busy_cycles);
                    end
                end
                busy_cnt = 0;
            end
            if (probe && exp_probe.size() != 0) begin
                p  = exp_probe.pop_front();
                nm = probe_name.pop_front();
                case (p.kind)
                    K_DATA:  act = data;
                    K_BUSY:  act = {31'd0, busy};
                    K_ERR:   act = {31'd0, err};
                    default: act = checksum;
                endcase
                checks++;
                if (act !== p.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h required %h", nm, act, p.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int kind, input logic [31:0] a,
                                input logic [31:0] val, input string name);
        addr = a;
        exp_probe.push_back('{kind, val});
        probe_name.push_back(name);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic start_load(input logic [7:0] n);
        addr   = 32'd0;
        start  = 1'b1;
        nwords = n;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_ready_timeout: byte_ready=0 required 1");
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) tick();
        end
    endtask

    task automatic wait_done();
        int w = 0;
        while (exp_done.size() != 0 && w < 40) begin
            tick();
            w++;
        end
        if (exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: done=0 required 1");
            exp_done.delete();
        end
    endtask

    task automatic apply_stimulus();
        logic [31:0] sum;

        rst = 1'b1; start = 1'b0; nwords = 8'd0;
        byte_valid = 1'b0; byte_data = 8'd0; addr = 32'd0;
        tick(); tick();
        rst = 1'b0;
        check_output(K_BUSY, 32'd0, 32'd0, "reset_busy");
        check_output(K_ERR,  32'd0, 32'd0, "reset_err");
        check_output(K_SUM,  32'd0, 32'd0, "reset_checksum");

        // Two words, byte_valid held high.
        exp_done.push_back('{32'h00B0_07A0, 8});
        start_load(8'd2);
        send_word(32'h0010_0513, 1'b0);
        send_word(32'h00A0_02B3, 1'b0);
        wait_done();
        check_output(K_DATA, 32'd0, 32'h0010_0513, "basic_word0");
        check_output(K_DATA, 32'd4, 32'h00A0_02B3, "basic_word1");
        check_output(K_SUM,  32'd0, 32'h00B0_07A0, "basic_checksum");

        // Same words with a bubble after every byte: done lands in cycle 16.
        exp_done.push_back('{32'h00B0_07A0, 15});
        start_load(8'd2);
        send_word(32'h0010_0513, 1'b1);
        send_word(32'h00A0_02B3, 1'b1);
        wait_done();
        check_output(K_DATA, 32'd0, 32'h0010_0513, "gapped_word0");
        check_output(K_DATA, 32'd4, 32'h00A0_02B3, "gapped_word1");

        start_load(8'd0);
        check_output(K_ERR,  32'd0, 32'd1, "zero_err");
        check_output(K_BUSY, 32'd0, 32'd0, "zero_busy");
        check_output(K_SUM,  32'd0, 32'd0, "zero_checksum_cleared");
        start_load(8'd200);
        check_output(K_ERR,  32'd0, 32'd1, "over_err");
        check_output(K_BUSY, 32'd0, 32'd0, "over_busy");

        // Legal start clears err; one probe cycle stalls the stream.
        exp_done.push_back('{32'h1234_5678, 5});
        start_load(8'd1);
        check_output(K_ERR, 32'd0, 32'd0, "legal_clears_err");
        send_word(32'h1234_5678, 1'b0);
        wait_done();
        check_output(K_DATA, 32'd0, 32'h1234_5678, "one_word0");
        check_output(K_DATA, 32'd4, 32'h00A0_02B3, "one_word1_kept");

        start_load(8'd2);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output(K_BUSY, 32'd0, 32'd0, "midreset_busy");
        check_output(K_SUM,  32'd0, 32'd0, "midreset_checksum");
        check_output(K_DATA, 32'd0, 32'hDEAD_BEEF, "midreset_word0");
        check_output(K_DATA, 32'd4, 32'h00A0_02B3, "midreset_word1_kept");

        // Fresh single-word load after the reset: stale partial bytes must be gone.
        exp_done.push_back('{32'h0BAD_F00D, 4});
        start_load(8'd1);
        send_word(32'h0BAD_F00D, 1'b0);
        wait_done();
        check_output(K_DATA, 32'd0, 32'h0BAD_F00D, "single_word0");

        sum = 32'd0;
        for (int i = 0; i < 128; i++) begin
            words[i] = {8'(i), 8'(255 - i), 8'(i * 7), 8'(i) ^ 8'hA5};
            sum ^= words[i];
        end
        exp_done.push_back('{sum, 512});
        start_load(8'd128);
        for (int i = 0; i < 128; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (i == 50 && b == 1) begin
                    start  = 1'b1;
                    nwords = 8'd3;
                end
                send_byte(words[i][8*b +: 8]);
                start  = 1'b0;
                nwords = 8'd128;
            end
        end
        wait_done();
        check_output(K_DATA, 32'h0000_01FC, words[127], "full_last");
        check_output(K_DATA, 32'h0000_01FF, words[127], "full_last_lowbits");
        check_output(K_DATA, 32'h0000_0000, words[0],   "full_first");
        check_output(K_DATA, 32'h0000_0200, words[0],   "full_wrap");
        check_output(K_DATA, 32'h0000_0100, words[64],  "full_mid");
        check_output(K_SUM,  32'd0,         sum,        "full_checksum");
    endtask

    initial begin
        apply_stimulus();
        tick();
        if (exp_probe.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL probe_queue: %0d probes left, required 0", exp_probe.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
